// File: rtl/fft_pkg.sv
// Shared widths, lane/twiddle types and the W16^k twiddle table for the 16-point FFT datapath.
package fft_pkg;

    localparam int LANE_W  = 34;
    localparam int COMP_W  = 17;
    localparam int TW_W    = 16;
    localparam int TW_FRAC = 14;
    localparam int N_PT    = 16;
    localparam int N_LANE  = 4;
    localparam int DATA_W  = N_LANE * LANE_W;
    localparam int BEAT_W  = $clog2(N_PT);

    typedef struct packed {
        logic [COMP_W-1:0] re;
        logic [COMP_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [TW_W-1:0] re;
        logic [TW_W-1:0] im;
    } tw_t;

    // W16^k in Q1.14: re = round(16384*cos(2*pi*k/16)), im = -round(16384*sin(2*pi*k/16))
    localparam tw_t TW_ROM [0:N_PT/2-1] = '{
        '{ 16'sd16384,  16'sd0     },
        '{ 16'sd15137, -16'sd6270  },
        '{ 16'sd11585, -16'sd11585 },
        '{ 16'sd6270,  -16'sd15137 },
        '{ 16'sd0,     -16'sd16384 },
        '{-16'sd6270,  -16'sd15137 },
        '{-16'sd11585, -16'sd11585 },
        '{-16'sd15137, -16'sd6270  }
    };

endpackage

// File: rtl/fft_butterfly_if.sv
// Valid/ready stream bundle carrying four-lane complex beats into and out of the butterfly stage.
interface fft_butterfly_if;
    import fft_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              frame_last;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, frame_last
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, frame_last
    );

endinterface

// File: rtl/fft_bfly_core.sv
// One butterfly's S2 (four products) and S3 (round, add/sub, halve, reduce); stages advance only on en.
// Reduction to 17 bits saturates when FFT_BFLY_SAT_EN is defined, otherwise wraps.
module fft_bfly_core
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  cplx_t a,
    input  cplx_t b,
    input  tw_t   w,
    output cplx_t a_out,
    output cplx_t b_out
);

    localparam int PROD_W = COMP_W + TW_W;
    localparam int ACC_W  = PROD_W + 1;
    localparam int P_W    = ACC_W - TW_FRAC;
    localparam int SUM_W  = P_W + 1;

`ifdef FFT_BFLY_SAT_EN
    localparam logic signed [SUM_W-1:0] MAX_V = 21'sd65535;
    localparam logic signed [SUM_W-1:0] MIN_V = -21'sd65536;
`endif

    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    cplx_t                    a_s2;
    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [P_W-1:0]    p_re, p_im;
    logic signed [SUM_W-1:0]  sum_re, sum_im, dif_re, dif_im;

    function automatic logic [COMP_W-1:0] fit(input logic signed [SUM_W-1:0] x);
`ifdef FFT_BFLY_SAT_EN
        if (x > MAX_V)
            return COMP_W'(MAX_V);
        else if (x < MIN_V)
            return COMP_W'(MIN_V);
        else
            return COMP_W'(x);
`else
        return COMP_W'(x);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            a_s2 <= '0;
        end else if (en) begin
            p_rr <= PROD_W'($signed(b.re)) * PROD_W'($signed(w.re));
            p_ii <= PROD_W'($signed(b.im)) * PROD_W'($signed(w.im));
            p_ri <= PROD_W'($signed(b.re)) * PROD_W'($signed(w.im));
            p_ir <= PROD_W'($signed(b.im)) * PROD_W'($signed(w.re));
            a_s2 <= a;
        end
    end

    // Round-half-up back to integer scale, then halve the sum/difference with the same rounding.
    assign acc_re = ACC_W'(p_rr) - ACC_W'(p_ii);
    assign acc_im = ACC_W'(p_ri) + ACC_W'(p_ir);
    assign p_re   = P_W'((acc_re + ACC_W'(2 ** (TW_FRAC - 1))) >>> TW_FRAC);
    assign p_im   = P_W'((acc_im + ACC_W'(2 ** (TW_FRAC - 1))) >>> TW_FRAC);
    assign sum_re = (SUM_W'($signed(a_s2.re)) + SUM_W'(p_re) + SUM_W'(1)) >>> 1;
    assign sum_im = (SUM_W'($signed(a_s2.im)) + SUM_W'(p_im) + SUM_W'(1)) >>> 1;
    assign dif_re = (SUM_W'($signed(a_s2.re)) - SUM_W'(p_re) + SUM_W'(1)) >>> 1;
    assign dif_im = (SUM_W'($signed(a_s2.im)) - SUM_W'(p_im) + SUM_W'(1)) >>> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            a_out.re <= fit(sum_re);
            a_out.im <= fit(sum_im);
            b_out.re <= fit(dif_re);
            b_out.im <= fit(dif_im);
        end
    end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly stage, two butterflies per beat, 3-cycle latency at 1 beat/cycle.
// Whole pipeline freezes while out_valid & !out_ready; FFT_BFLY_SAT_EN selects saturating output.
module fft_butterfly
    import fft_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    fft_butterfly_if.slave  bus
);

    logic              en;
    logic [BEAT_W-1:0] beat;
    logic [2:0]        k0, k1;
    logic              s1_vld, s1_last, s2_vld, s2_last, s3_vld, s3_last;
    logic [DATA_W-1:0] s1_dat;
    tw_t               s1_w0, s1_w1;
    cplx_t             lane0, lane1, lane2, lane3;
    cplx_t             a0_out, b0_out, a1_out, b1_out;

    assign en           = !s3_vld || bus.out_ready;
    assign bus.in_ready = en;

    assign k0 = {beat[1:0], 1'b0};
    assign k1 = {beat[1:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_dat  <= '0;
            s1_w0   <= '0;
            s1_w1   <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s3_vld  <= 1'b0;
            s3_last <= 1'b0;
        end else if (en) begin
            if (bus.in_valid)
                beat <= beat + 1'b1;
            s1_vld  <= bus.in_valid;
            s1_last <= bus.in_valid && (beat == BEAT_W'(N_PT - 1));
            s1_dat  <= bus.data_in;
            s1_w0   <= TW_ROM[k0];
            s1_w1   <= TW_ROM[k1];
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s3_vld  <= s2_vld;
            s3_last <= s2_last;
        end
    end

    assign lane0 = s1_dat[0*LANE_W +: LANE_W];
    assign lane1 = s1_dat[1*LANE_W +: LANE_W];
    assign lane2 = s1_dat[2*LANE_W +: LANE_W];
    assign lane3 = s1_dat[3*LANE_W +: LANE_W];

    fft_bfly_core u_pair0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (lane0),
        .b     (lane1),
        .w     (s1_w0),
        .a_out (a0_out),
        .b_out (b0_out)
    );

    fft_bfly_core u_pair1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (lane2),
        .b     (lane3),
        .w     (s1_w1),
        .a_out (a1_out),
        .b_out (b1_out)
    );

    assign bus.out_valid  = s3_vld;
    assign bus.frame_last = s3_last;
    assign bus.data_out   = {b1_out, a1_out, b0_out, a0_out};

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed vector bench for fft_butterfly: vector table plus frame, stall and mid-frame reset sequences.
module tb_fft_butterfly;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_butterfly_if bus();

    fft_butterfly dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dexp;
    } vec_t;

    localparam int NV = 5;
    vec_t vec [NV];

    int n_cmp = 0;
    int n_bad = 0;

    // Lane0 of B=(16384,0), A=0 on even k = 0,2,4,6; lane2 of the same on odd k = 1,3,5,7
    int ke_re [4] = '{8192, 5793, 0, -5792};
    int ke_im [4] = '{0, -5792, -8192, -5792};
    int ko_re [4] = '{7569, 3135, -3135, -7568};

    function automatic logic [DATA_W-1:0] lanes(input int r0, input int i0, input int r1, input int i1,
                                                  input int r2, input int i2, input int r3, input int i3);
        logic [DATA_W-1:0] d;
        d = {r3[16:0], i3[16:0], r2[16:0], i2[16:0], r1[16:0], i1[16:0], r0[16:0], i0[16:0]};
        return d;
    endfunction

    function automatic int comp(input logic [DATA_W-1:0] d, input int idx);
        logic signed [16:0] t;
        t = d[(idx / 2) * LANE_W + ((idx % 2 == 0) ? COMP_W : 0) +: COMP_W];
        return int'(t);
    endfunction

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic check_all(input string name, input logic [DATA_W-1:0] expd);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_c%0d", name, i), comp(bus.data_out, i), comp(expd, i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [DATA_W-1:0] probe;
    int ovf_pos, ovf_neg, j;

    initial begin
`ifdef FFT_BFLY_SAT_EN
        ovf_pos = 65535;
        ovf_neg = -65536;
`else
        ovf_pos = -51965;
        ovf_neg = 51965;
`endif
        vec[0] = '{lanes(1000, 0, 200, 0, 100, -100, 16384, 0),
                   lanes(600, 0, 400, 0, 7619, -3185, -7518, 3085)};
        vec[1] = '{lanes(65535, 0, 65535, 65535, 0, 0, 0, 16384),
                   lanes(ovf_pos, 0, -13572, 0, 7569, 3135, -7568, -3135)};
        vec[2] = '{lanes(0, 0, 100, 0, -2000, 3000, 16384, 0),
                   lanes(0, -50, 0, 50, -4135, -6068, 2135, 9069)};
        vec[3] = '{lanes(-65536, 0, 65535, -65536, 0, 0, 0, 16384),
                   lanes(ovf_neg, 1, 13572, 0, 3135, -7568, -3135, 7569)};
        vec[4] = '{lanes(3, -3, 1, 1, 0, 0, 0, 16384),
                   lanes(2, -1, 1, -2, 3135, 7569, -3135, -7568)};

        // Reset state
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_frame_last", bus.frame_last, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check_all("rst_data_out", '0);
        step();
        step();
        rst_n = 1'b1;

        // Table vectors, back to back from beat 0
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < NV + 4; cyc++) begin
            if (cyc < NV) begin
                bus.in_valid = 1'b1;
                bus.data_in  = vec[cyc].din;
            end else begin
                idle();
            end
            step();
            j = cyc - 2;
            check($sformatf("vec_valid_cyc%0d", cyc), bus.out_valid, int'(j >= 0 && j < NV));
            if (j >= 0 && j < NV && bus.out_valid) begin
                check_all($sformatf("vec%0d", j), vec[j].dexp);
                check($sformatf("vec%0d_last", j), bus.frame_last, 0);
            end
        end

        // Full frame plus one: frame_last only on the 16th output, 17th restarts at k=0
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 17) begin
                bus.in_valid = 1'b1;
                bus.data_in  = lanes(0, 0, 16384, 0, 0, 0, 16384, 0);
            end else begin
                idle();
            end
            step();
            j = cyc - 2;
            check($sformatf("frm_valid_cyc%0d", cyc), bus.out_valid, int'(j >= 0 && j < 17));
            if (j >= 0 && j < 17) begin
                check($sformatf("frm%0d_last", j), bus.frame_last, int'(j == 15));
                check($sformatf("frm%0d_re", j), comp(bus.data_out, 0), ke_re[j % 4]);
                check($sformatf("frm%0d_im", j), comp(bus.data_out, 1), ke_im[j % 4]);
            end
        end

        // Stall with full pipeline: hold 5 cycles, then three held beats drain in order
        do_reset();
        for (int n = 0; n < 3; n++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = lanes(10 * (n + 1), 0, 0, 0, 0, 0, 16384, 0);
            step();
        end
        bus.data_in   = lanes(40, 0, 0, 0, 0, 0, 16384, 0);
        bus.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_in_ready", c), bus.in_ready, 0);
            check($sformatf("stall%0d_valid", c), bus.out_valid, 1);
            check($sformatf("stall%0d_re", c), comp(bus.data_out, 0), 5);
            check($sformatf("stall%0d_k", c), comp(bus.data_out, 4), ko_re[0]);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        for (int m = 1; m <= 3; m++) begin
            step();
            if (m == 1)
                idle();
            check($sformatf("drain%0d_valid", m), bus.out_valid, 1);
            check($sformatf("drain%0d_re", m), comp(bus.data_out, 0), 5 * (m + 1));
            check($sformatf("drain%0d_k", m), comp(bus.data_out, 4), ko_re[m]);
        end
        step();
        check("drain_no_dup", bus.out_valid, 0);

        // Reset mid-frame after 7 beats
        do_reset();
        for (int n = 0; n < 7; n++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = lanes(0, 0, 16384, 0, 0, 0, 16384, 0);
            step();
        end
        check("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_last", bus.frame_last, 0);
        check_all("midrst_data", '0);
        idle();
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = lanes(0, 0, 16384, 0, 0, 0, 16384, 0);
        step();
        idle();
        step();
        check("postrst_no_stale", bus.out_valid, 0);
        step();
        check("postrst_valid", bus.out_valid, 1);
        probe = bus.data_out;
        check("postrst_re", comp(probe, 0), ke_re[0]);
        check("postrst_im", comp(probe, 1), ke_im[0]);
        check("postrst_k1", comp(probe, 4), ko_re[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
